qracc_seq_scheduler: RTL and testbench
======================================

# qracc_seq_scheduler

Job-level controller that sequences the bit-serial MAC accelerator (`seq_acc`) over a run of input vectors. On `start_i` it fetches `job_len_i` activation vectors from the input buffer, issues each one to the accelerator with a valid/ready handshake, and collects each accelerator result. Results are written to consecutive output-buffer addresses. It sits between the top-level QR accelerator control/CSR logic and `seq_acc`.

## Interface
Parameters:
- `inputBits`, 5: bits per input element.
- `inputElements`, 128: elements per input vector.
- `outputBits`, 4: bits per output element.
- `outputElements`, 32: elements per output vector.
- `addrBits`, 8: buffer address width; also the job-length width.

Ports:
- `clk` in 1: clock.
- `nrst` in 1: asynchronous active-low reset.
- `start_i` in 1: job start pulse.
- `job_len_i` in addrBits: number of vectors; 0 is legal.
- `ifmap_base_i` in addrBits: input buffer base address.
- `ofmap_base_i` in addrBits: output buffer base address.
- `busy_o` out 1: a job is active.
- `done_o` out 1: one-cycle pulse at job end.
- `err_o` out 1: sticky protocol error flag.
- `ibuf_rd_en_o` out 1: input buffer read enable.
- `ibuf_rd_addr_o` out addrBits: input buffer read address.
- `ibuf_rd_data_i` in inputElements*inputBits: read data, valid 1 cycle after `ibuf_rd_en_o`.
- `acc_valid_o` out 1: vector offered to `seq_acc` (drives `mac_valid_i`).
- `acc_ready_i` in 1: `seq_acc` ready.
- `acc_data_o` out inputElements*inputBits: vector to `seq_acc`.
- `acc_out_valid_i` in 1: `seq_acc` result valid.
- `acc_out_data_i` in outputElements*outputBits: `seq_acc` result.
- `obuf_wr_en_o` out 1: output buffer write enable.
- `obuf_wr_addr_o` out addrBits: output buffer write address.
- `obuf_wr_data_o` out outputElements*outputBits: output buffer write data.

## Operation
- FSM states:
  - IDLE: on `start_i`, latch bases and length. Go to FETCH, or to DONE if `job_len_i`==0.
  - FETCH: `ibuf_rd_en_o`=1, `ibuf_rd_addr_o` = ifmap_base + issued. Next state: LOAD.
  - LOAD: capture `ibuf_rd_data_i` into a data register. Next state: ISSUE.
  - ISSUE: `acc_valid_o`=1, data register held stable. On `acc_valid_o && acc_ready_i`, increment issued. Go to FETCH if issued < len, else DRAIN.
  - DRAIN: wait until retired == len, then go to DONE.
  - DONE: `done_o`=1 for one cycle. Next state: IDLE.
- Retire path runs in every state. `acc_out_valid_i` registers result and address: next cycle `obuf_wr_en_o`=1, `obuf_wr_addr_o` = ofmap_base + retired, `obuf_wr_data_o` = result. Retired then increments.
- Counters are addrBits wide. Address sums wrap modulo 2^addrBits.
- `busy_o` = (state != IDLE).
- Error cases set `err_o`, which clears only on reset:
  - `acc_out_valid_i` while IDLE: result dropped.
  - `acc_out_valid_i` when retired == len: result dropped.
- `start_i` while busy is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, data register 0.
- Reset mid-job aborts immediately. No `done_o`. `seq_acc` shares `nrst`.
- `start_i` at cycle 0 (IDLE):
  - FETCH at cycle 1.
  - LOAD at cycle 2.
  - `acc_valid_o` first high at cycle 3.
- `acc_valid_o` stays high until accepted. Data is constant while valid.
- Next vector is offered at the earliest 3 cycles after acceptance.
- Result-to-write latency is exactly 1 cycle.
- `done_o` is asserted the cycle after the final `obuf_wr_en_o`. For len 0, `done_o` is at cycle 1.
- Simultaneous issue handshake and retire in one cycle: both counters update independently.

## Structure
- `qracc_pkg` gets `seq_sched_state_t`, the 3-bit enum {IDLE, FETCH, LOAD, ISSUE, DRAIN, DONE}.
- No sub-module. FSM, two counters, and the data and write registers are all local.

## Test plan
- len=1, base 0x10/0x20, `acc_ready_i`=1, result 7 cycles after accept:
  - read at 0x10 at cycle 1, `acc_valid_o` at cycle 3.
  - write to 0x20 one cycle after `acc_out_valid_i`.
  - `done_o` the cycle after that write.
- len=4, `acc_ready_i` low for 5 cycles per vector:
  - `acc_valid_o`/`acc_data_o` stable while stalled.
  - reads at ifmap_base+0..3, writes at ofmap_base+0..3 in order.
  - exactly one `done_o`.
- len=0 -> `done_o` at cycle 1, no reads, no writes, `busy_o` high for one cycle.
- ifmap_base=0xFE, len=3 -> read addresses 0xFE, 0xFF, 0x00.
- Spurious `acc_out_valid_i` in IDLE -> no write, `err_o`=1 until reset. Second `start_i` mid-job -> ignored.
- `nrst` low during ISSUE of vector 2 of 4 -> all outputs 0 immediately. After release: IDLE, no `done_o`.

Source files
------------

// File: rtl/qracc_pkg.sv
// Shared types for the QR accelerator control blocks.
// Holds the job-scheduler FSM encoding used by qracc_seq_scheduler.
package qracc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } seq_sched_state_t;

endpackage

// File: rtl/qracc_seq_scheduler_if.sv
// Bundle of job-control, input-buffer, accelerator and output-buffer signals
// around qracc_seq_scheduler. master = the scheduler, slave = its surroundings.
interface qracc_seq_scheduler_if #(
  parameter int inputBits      = 5,
  parameter int inputElements  = 128,
  parameter int outputBits     = 4,
  parameter int outputElements = 32,
  parameter int addrBits       = 8
);
  localparam int InW  = inputBits * inputElements;
  localparam int OutW = outputBits * outputElements;

  logic                start_i;
  logic [addrBits-1:0] job_len_i;
  logic [addrBits-1:0] ifmap_base_i;
  logic [addrBits-1:0] ofmap_base_i;
  logic                busy_o;
  logic                done_o;
  logic                err_o;

  logic                ibuf_rd_en_o;
  logic [addrBits-1:0] ibuf_rd_addr_o;
  logic [InW-1:0]      ibuf_rd_data_i;

  logic                acc_valid_o;
  logic                acc_ready_i;
  logic [InW-1:0]      acc_data_o;
  logic                acc_out_valid_i;
  logic [OutW-1:0]     acc_out_data_i;

  logic                obuf_wr_en_o;
  logic [addrBits-1:0] obuf_wr_addr_o;
  logic [OutW-1:0]     obuf_wr_data_o;

  modport master (
    input  start_i, job_len_i, ifmap_base_i, ofmap_base_i,
    output busy_o, done_o, err_o,
    output ibuf_rd_en_o, ibuf_rd_addr_o,
    input  ibuf_rd_data_i,
    output acc_valid_o, acc_data_o,
    input  acc_ready_i, acc_out_valid_i, acc_out_data_i,
    output obuf_wr_en_o, obuf_wr_addr_o, obuf_wr_data_o
  );

  modport slave (
    output start_i, job_len_i, ifmap_base_i, ofmap_base_i,
    input  busy_o, done_o, err_o,
    input  ibuf_rd_en_o, ibuf_rd_addr_o,
    output ibuf_rd_data_i,
    input  acc_valid_o, acc_data_o,
    output acc_ready_i, acc_out_valid_i, acc_out_data_i,
    input  obuf_wr_en_o, obuf_wr_addr_o, obuf_wr_data_o
  );

endinterface

// File: rtl/qracc_seq_scheduler.sv
// Job-level sequencer for the bit-serial MAC accelerator: fetches job_len vectors,
// issues them with valid/ready and writes every returned result to the output buffer.
module qracc_seq_scheduler
  import qracc_pkg::*;
#(
  parameter int inputBits      = 5,
  parameter int inputElements  = 128,
  parameter int outputBits     = 4,
  parameter int outputElements = 32,
  parameter int addrBits       = 8
) (
  input logic                   clk,
  input logic                   nrst,
  qracc_seq_scheduler_if.master bus
);
  localparam int InW  = inputBits * inputElements;
  localparam int OutW = outputBits * outputElements;

  seq_sched_state_t    state_q, state_d;
  logic [addrBits-1:0] len_q, issued_q, retired_q;
  logic [addrBits-1:0] ifmap_base_q, ofmap_base_q;
  logic [addrBits-1:0] issued_next;
  logic [InW-1:0]      data_q;
  logic                wr_en_q;
  logic [addrBits-1:0] wr_addr_q;
  logic [OutW-1:0]     wr_data_q;
  logic                err_q;
  logic                start_ok, issue_fire, retire_ok, retire_bad;

  assign start_ok    = (state_q == IDLE) && bus.start_i;
  assign issue_fire  = (state_q == ISSUE) && bus.acc_ready_i;
  assign issued_next = issued_q + addrBits'(1);

  // A result is only accepted while a job still owes results; anything else is dropped.
  assign retire_ok  = bus.acc_out_valid_i && (state_q != IDLE) && (retired_q != len_q);
  assign retire_bad = bus.acc_out_valid_i && !retire_ok;

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = (bus.job_len_i == '0) ? DONE : FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = ISSUE;
      ISSUE:   if (issue_fire) state_d = (issued_next < len_q) ? FETCH : DRAIN;
      DRAIN:   if (retired_q == len_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      retired_q    <= '0;
      ifmap_base_q <= '0;
      ofmap_base_q <= '0;
      // NOTE: the wide vector register is reset too, so acc_data_o is defined from reset onward.
      data_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        len_q        <= bus.job_len_i;
        ifmap_base_q <= bus.ifmap_base_i;
        ofmap_base_q <= bus.ofmap_base_i;
        issued_q     <= '0;
        retired_q    <= '0;
      end

      if (state_q == LOAD) data_q <= bus.ibuf_rd_data_i;
      if (issue_fire) issued_q <= issued_next;

      // Retire path is independent of the issue FSM and may update in the same cycle.
      wr_en_q <= retire_ok;
      if (retire_ok) begin
        wr_addr_q <= ofmap_base_q + retired_q;
        wr_data_q <= bus.acc_out_data_i;
        retired_q <= retired_q + addrBits'(1);
      end

      if (retire_bad) err_q <= 1'b1;
    end
  end

  assign bus.busy_o         = (state_q != IDLE);
  assign bus.done_o         = (state_q == DONE);
  assign bus.err_o          = err_q;
  assign bus.ibuf_rd_en_o   = (state_q == FETCH);
  assign bus.ibuf_rd_addr_o = (state_q == FETCH) ? (ifmap_base_q + issued_q) : '0;
  assign bus.acc_valid_o    = (state_q == ISSUE);
  assign bus.acc_data_o     = data_q;
  assign bus.obuf_wr_en_o   = wr_en_q;
  assign bus.obuf_wr_addr_o = wr_addr_q;
  assign bus.obuf_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_qracc_seq_scheduler.sv
// Directed bench for qracc_seq_scheduler with input-buffer and accelerator models
// and a scoreboard of expected reads, issued vectors and output writes.
module tb_qracc_seq_scheduler;
  localparam int IN_W  = 640;
  localparam int OUT_W = 128;
  localparam int AW    = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  qracc_seq_scheduler_if bus_if ();
  qracc_seq_scheduler dut (.clk(clk), .nrst(nrst), .bus(bus_if));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] vec_of(input logic [AW-1:0] a);
    logic [IN_W-1:0] v;
    v = '0;
    for (int k = 0; k < 20; k++) v[k*32 +: 32] = {a, 8'(k), ~a, a ^ 8'(k * 7)};
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] res_of(input logic [IN_W-1:0] v);
    return v[127:0] ^ v[639:512] ^ {4{32'hC3A5_0F1E}};
  endfunction

  // Scoreboard queues filled when a job is launched
  logic [AW-1:0]    rd_q[$];
  logic [IN_W-1:0]  acc_q[$];
  logic [AW-1:0]    wr_addr_q[$];
  logic [OUT_W-1:0] wr_data_q[$];

  // Input buffer: data one cycle after the read enable
  always @(posedge clk)
    if (bus_if.ibuf_rd_en_o) bus_if.ibuf_rd_data_i <= vec_of(bus_if.ibuf_rd_addr_o);

  // Accelerator model: ready stalls per vector, result after res_delay cycles
  int cyc = 0;
  int stall_cycles = 0, stall_left = 0, res_delay = 1;
  int acc_cnt = 0, last_res_cyc = -1;
  bit inject = 1'b0;
  int pend_t[$];
  logic [OUT_W-1:0] pend_d[$];

  always begin
    @(posedge clk);
    if (nrst && bus_if.acc_valid_o && bus_if.acc_ready_i) begin
      pend_t.push_back(cyc + res_delay);
      pend_d.push_back(res_of(bus_if.acc_data_o));
      stall_left = stall_cycles;
      acc_cnt++;
    end
    cyc++;
    #1;
    if (!nrst) begin
      pend_t.delete();
      pend_d.delete();
    end
    bus_if.acc_out_valid_i = 1'b0;
    if (inject) begin
      bus_if.acc_out_valid_i = 1'b1;
      bus_if.acc_out_data_i  = 128'hDEAD_BEEF;
    end else if (pend_t.size() > 0 && pend_t[0] == cyc) begin
      bus_if.acc_out_valid_i = 1'b1;
      bus_if.acc_out_data_i  = pend_d.pop_front();
      void'(pend_t.pop_front());
      last_res_cyc = cyc;
    end
    if (bus_if.acc_valid_o && stall_left > 0) begin
      bus_if.acc_ready_i = 1'b0;
      stall_left--;
    end else begin
      bus_if.acc_ready_i = 1'b1;
    end
  end

  // Monitor on the falling edge
  int first_rd_cyc = -1, first_valid_cyc = -1, last_wr_cyc = -1, done_cyc = -1;
  int done_cnt = 0, rd_cnt = 0, wr_cnt = 0, busy_cnt = 0;
  bit hold = 1'b0;
  logic [IN_W-1:0] held;

  always @(negedge clk) begin
    if (!nrst) begin
      hold = 1'b0;
    end else begin
      if (bus_if.busy_o) busy_cnt++;
      if (bus_if.ibuf_rd_en_o) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("rd_expected", rd_q.size() != 0, 1'b1);
        if (rd_q.size() != 0) check("rd_addr", bus_if.ibuf_rd_addr_o, rd_q.pop_front());
      end
      if (hold) check("valid_held", bus_if.acc_valid_o, 1'b1);
      if (bus_if.acc_valid_o) begin
        if (!hold) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          check("acc_expected", acc_q.size() != 0, 1'b1);
          if (acc_q.size() != 0) check("acc_data", bus_if.acc_data_o, acc_q.pop_front());
        end else begin
          check("acc_data_stable", bus_if.acc_data_o, held);
        end
        held = bus_if.acc_data_o;
        hold = !bus_if.acc_ready_i;
      end else begin
        hold = 1'b0;
      end
      if (bus_if.obuf_wr_en_o) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        check("wr_expected", wr_addr_q.size() != 0, 1'b1);
        if (wr_addr_q.size() != 0) begin
          check("wr_addr", bus_if.obuf_wr_addr_o, wr_addr_q.pop_front());
          check("wr_data", bus_if.obuf_wr_data_o, wr_data_q.pop_front());
        end
      end
      if (bus_if.done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int start_cyc = 0;

  task automatic launch(input logic [AW-1:0] ib, input logic [AW-1:0] ob, input logic [AW-1:0] len);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = ib + 8'(i);
      rd_q.push_back(a);
      acc_q.push_back(vec_of(a));
      wr_addr_q.push_back(ob + 8'(i));
      wr_data_q.push_back(res_of(vec_of(a)));
    end
    first_rd_cyc = -1; first_valid_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
    done_cnt = 0; rd_cnt = 0; wr_cnt = 0; busy_cnt = 0;
    stall_left = stall_cycles;
    @(posedge clk); #1;
    bus_if.start_i      = 1'b1;
    bus_if.job_len_i    = len;
    bus_if.ifmap_base_i = ib;
    bus_if.ofmap_base_i = ob;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != 0, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    bus_if.busy_o, 1'b0);
    check({tag, "_done"},    bus_if.done_o, 1'b0);
    check({tag, "_err"},     bus_if.err_o, 1'b0);
    check({tag, "_rd_en"},   bus_if.ibuf_rd_en_o, 1'b0);
    check({tag, "_rd_addr"}, bus_if.ibuf_rd_addr_o, '0);
    check({tag, "_valid"},   bus_if.acc_valid_o, 1'b0);
    check({tag, "_data"},    bus_if.acc_data_o, '0);
    check({tag, "_wr_en"},   bus_if.obuf_wr_en_o, 1'b0);
    check({tag, "_wr_addr"}, bus_if.obuf_wr_addr_o, '0);
    check({tag, "_wr_data"}, bus_if.obuf_wr_data_o, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, rd_before;
    bus_if.start_i = 1'b0; bus_if.job_len_i = '0;
    bus_if.ifmap_base_i = '0; bus_if.ofmap_base_i = '0;
    bus_if.ibuf_rd_data_i = '0; bus_if.acc_ready_i = 1'b0;
    bus_if.acc_out_valid_i = 1'b0; bus_if.acc_out_data_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    nrst = 1'b1;

    // Single vector with fixed result latency
    stall_cycles = 0; res_delay = 7;
    launch(8'h10, 8'h20, 8'd1);
    wait_done("len1", 100);
    check("len1_first_read_cycle", first_rd_cyc, start_cyc + 1);
    check("len1_first_valid_cycle", first_valid_cyc, start_cyc + 3);
    check("len1_write_latency", last_wr_cyc, last_res_cyc + 1);
    check("len1_done_after_write", done_cyc, last_wr_cyc + 1);
    check("len1_done_count", done_cnt, 1);
    check("len1_write_count", wr_cnt, 1);

    // Four vectors, ready stalled five cycles per vector
    stall_cycles = 5; res_delay = 3;
    launch(8'h30, 8'h50, 8'd4);
    wait_done("len4", 300);
    check("len4_first_valid_cycle", first_valid_cyc, start_cyc + 3);
    check("len4_done_count", done_cnt, 1);
    check("len4_read_count", rd_cnt, 4);
    check("len4_write_count", wr_cnt, 4);
    check("len4_done_after_write", done_cyc, last_wr_cyc + 1);

    // Zero-length job
    launch(8'h44, 8'h66, 8'd0);
    wait_done("len0", 20);
    check("len0_done_cycle", done_cyc, start_cyc + 1);
    check("len0_busy_cycles", busy_cnt, 1);
    check("len0_read_count", rd_cnt, 0);
    check("len0_write_count", wr_cnt, 0);

    // Address wrap with issue and retire landing in the same cycle
    stall_cycles = 0; res_delay = 3;
    launch(8'hFE, 8'hFF, 8'd3);
    wait_done("wrap", 200);
    check("wrap_read_count", rd_cnt, 3);
    check("wrap_write_count", wr_cnt, 3);
    check("wrap_done_count", done_cnt, 1);

    // Spurious result while idle, then a second start mid-job
    wr_cnt = 0;
    @(posedge clk); #1; inject = 1'b1;
    @(posedge clk); #1; inject = 1'b0;
    repeat (3) @(negedge clk);
    check("spurious_err", bus_if.err_o, 1'b1);
    check("spurious_no_write", wr_cnt, 0);
    stall_cycles = 2; res_delay = 2;
    launch(8'h80, 8'h90, 8'd2);
    repeat (2) @(posedge clk);
    #1;
    bus_if.start_i = 1'b1; bus_if.job_len_i = 8'd5; bus_if.ifmap_base_i = 8'h00;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    wait_done("restart", 200);
    check("restart_done_count", done_cnt, 1);
    check("restart_read_count", rd_cnt, 2);
    check("restart_write_count", wr_cnt, 2);
    check("restart_err_sticky", bus_if.err_o, 1'b1);

    // Reset while vector 2 of 4 is offered
    stall_cycles = 20; res_delay = 2;
    n = acc_cnt;
    launch(8'h00, 8'h10, 8'd4);
    begin
      int k;
      k = 0;
      while (!(acc_cnt == n + 1 && bus_if.acc_valid_o) && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("abort_reached_issue2", bus_if.acc_valid_o && (acc_cnt == n + 1), 1'b1);
    nrst = 1'b0;
    #1;
    check_outputs_zero("abort");
    rd_q.delete(); acc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    rd_before = rd_cnt;
    done_cnt = 0;
    repeat (6) @(negedge clk);
    check("abort_idle", bus_if.busy_o, 1'b0);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_reads", rd_cnt, rd_before);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
